// File: rtl/restoring_divider_8bit.sv
// restoring_divider_8bit
//   Multi-cycle unsigned restoring divider that produces one quotient bit per
//   clock. A start/busy/done handshake fronts the datapath. Results are held
//   until the next operation completes.
//
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   request, sampled only in IDLE or DONE
//   dividend     in   [WIDTH-1:0] unsigned dividend, captured on accept
//   divisor      in   [WIDTH-1:0] unsigned divisor, captured on accept
//   busy         out  high while iterating
//   done         out  one-cycle pulse, results valid
//   quotient     out  [WIDTH-1:0] registered quotient
//   remainder    out  [WIDTH-1:0] registered remainder
//   div_by_zero  out  registered, set when divisor was zero at accept
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | iterating, one quotient bit per cycle
//   DONE  | results just loaded; start here begins the next operation
module restoring_divider_8bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dz_q, dz_d;

   logic [WIDTH:0]   s;
   logic [WIDTH:0]   sub;
   logic             bout;
   logic [WIDTH-1:0] diff;
   logic             accept_bit;
   logic [WIDTH-1:0] r_iter;
   logic [WIDTH-1:0] q_iter;

   // Trial subtract of the shifted partial remainder. The extra top bit of s
   // means the shifted value is >= 2^WIDTH and therefore always >= divisor;
   // the low WIDTH bits of diff are still correct in that case.
   always_comb begin
      s          = {r_q, q_q[WIDTH-1]};
      sub        = {1'b0, s[WIDTH-1:0]} - {1'b0, dsr_q};
      bout       = sub[WIDTH];
      diff       = sub[WIDTH-1:0];
      accept_bit = s[WIDTH] | ~bout;
      r_iter     = accept_bit ? diff : s[WIDTH-1:0];
      q_iter     = {q_q[WIDTH-2:0], accept_bit};
   end

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      q_d         = q_q;
      dsr_d       = dsr_q;
      count_d     = count_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dz_d        = dz_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               r_d     = '0;
               q_d     = dividend;
               dsr_d   = divisor;
               count_d = '0;
               if (divisor == '0) begin
                  // Zero divisor finishes immediately with saturated quotient.
                  state_d     = DONE;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dz_d        = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            r_d     = r_iter;
            q_d     = q_iter;
            count_d = count_q + 1'b1;
            if (count_q == LAST) begin
               state_d     = DONE;
               quotient_d  = q_iter;
               remainder_d = r_iter;
               dz_d        = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         r_q         <= '0;
         q_q         <= '0;
         dsr_q       <= '0;
         count_q     <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dz_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         q_q         <= q_d;
         dsr_q       <= dsr_d;
         count_q     <= count_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dz_q        <= dz_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_restoring_divider_8bit.sv
module tb_restoring_divider_8bit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [7:0] divisor = '0;
   logic       busy, done, div_by_zero;
   logic [7:0] quotient, remainder;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      int         at;
   } exp_t;

   exp_t sb[$];

   restoring_divider_8bit dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation,
   // including the edge count at which it appears.
   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: done=1 with nothing pending (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", div_by_zero, e.dz);
            chk("latency", cyc, e.at);
         end
      end
   end

   // Caller is just after a negedge. Returns just after the negedge where
   // done is seen, so a following call issues start in the DONE cycle.
   task automatic op(input logic [7:0] a, input logic [7:0] b, input bit hold);
      exp_t e;
      bit   seen;
      int   n;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      if (b == 8'd0) begin
         e.q = 8'hFF; e.r = a; e.dz = 1'b1; e.at = cyc + 1;
      end else begin
         e.q = a / b; e.r = a % b; e.dz = 1'b0; e.at = cyc + 1 + 8;
      end
      sb.push_back(e);
      @(negedge clk);
      seen = 1'b0;
      n = 0;
      while (!seen && n < 20) begin
         if (hold && n < 4) begin
            start    = 1'b1;
            dividend = ~a;
            divisor  = 8'd3;
         end else begin
            start = 1'b0;
         end
         chk("busy", busy, (b != 8'd0) && !done);
         if (done) begin
            seen  = 1'b1;
            start = 1'b0;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL done_timeout: no done for %0d/%0d after %0d cycles", a, b, n);
         sb.delete();
      end
   endtask

   typedef struct { logic [7:0] a; logic [7:0] b; } vec_t;
   vec_t vecs[$];

   initial begin
      vecs = '{'{8'd255, 8'd1}, '{8'd255, 8'd255}, '{8'd0, 8'd5}, '{8'd5, 8'd9},
               '{8'd200, 8'd128}, '{8'd200, 8'd0}, '{8'd9, 8'd3}, '{8'd0, 8'd0},
               '{8'd254, 8'd255}, '{8'd129, 8'd130}};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dz", div_by_zero, 0);
      rst = 1'b0;
      @(negedge clk);

      op(8'd100, 8'd7, 1'b0);
      foreach (vecs[i]) op(vecs[i].a, vecs[i].b, 1'b0);

      // start held with other operands during RUN must be ignored
      op(8'd77, 8'd6, 1'b1);
      op(8'd50, 8'd5, 1'b0);

      // reset in the middle of an operation: no done, everything cleared
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_quotient", quotient, 0);
      chk("mid_rst_remainder", remainder, 0);
      chk("mid_rst_dz", div_by_zero, 0);
      repeat (12) @(negedge clk);
      op(8'd17, 8'd4, 1'b0);

      for (int k = 0; k < 300; k++) begin
         logic [7:0] a, b;
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         if (k % 50 == 0) b = 8'd0;
         op(a, b, 1'b0);
         if (k % 7 == 0) repeat (2) @(negedge clk);
      end

      repeat (12) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      chk("final_done_low", done, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
